slice_serial_adder: RTL and testbench

- Multi-cycle wide adder control stage that drives a SLICE_W-bit carry-lookahead adder slice.
- Accepts a DATA_W-bit operand pair plus carry-in over a valid/ready handshake.
- Feeds the operands one slice per clock, least-significant slice first, registering the inter-slice carry.
- Presents the assembled DATA_W-bit sum and carry-out on a valid/ready output handshake; it trades latency for area in the datapath.

---
 rtl/slice_serial_adder.sv | 119 +++++++++++
 tb/tb_slice_serial_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_serial_adder.sv
// slice_serial_adder: adds two DATA_W-bit operands plus a carry-in by pushing
// them through one SLICE_W-bit carry-lookahead slice per clock, least
// significant slice first. A registered carry links consecutive slices and
// the finished sum/carry-out are offered on a valid/ready output handshake.
module slice_serial_adder #(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] A_in,
    input  logic [DATA_W-1:0] B_in,
    input  logic              C_1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] S,
    output logic              CO
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [DATA_W-1:0]   r_opA;
    logic [DATA_W-1:0]   r_opB;
    logic                r_carry;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_sum;
    logic                r_co;
    logic [SLICE_W-1:0]  w_sliceSum;
    logic                w_sliceCo;

    // Lookahead slice on the low SLICE_W bits of the operand shift registers.
    always_comb begin
        logic [SLICE_W-1:0] p;
        logic [SLICE_W-1:0] g;
        logic [SLICE_W:0]   c;
        p    = r_opA[SLICE_W-1:0] ^ r_opB[SLICE_W-1:0];
        g    = r_opA[SLICE_W-1:0] & r_opB[SLICE_W-1:0];
        c    = '0;
        c[0] = r_carry;
        for (int j = 0; j < SLICE_W; j++) begin
            c[j+1] = g[j] | (p[j] & c[j]);
        end
        w_sliceSum = p ^ c[SLICE_W-1:0];
        w_sliceCo  = c[SLICE_W];
    end

    // State register; reset drops any in-flight addition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: accept in IDLE, run NSLICE cycles, hold result until taken.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid)          w_nextState = RUN;
            RUN:     if (r_cnt == LAST_CNT) w_nextState = DONE;
            DONE:    if (out_ready)         w_nextState = IDLE;
            default:                        w_nextState = IDLE;
        endcase
    end

    // Datapath: load operands on accept, then consume one slice per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opA   <= '0;
            r_opB   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_opA   <= A_in;
                        r_opB   <= B_in;
                        r_carry <= C_1;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_cnt*SLICE_W +: SLICE_W] <= w_sliceSum;
                    r_carry <= w_sliceCo;
                    r_opA   <= r_opA >> SLICE_W;
                    r_opB   <= r_opB >> SLICE_W;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_co <= w_sliceCo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign S         = r_sum;
    assign CO        = r_co;

endmodule

// File: tb/tb_slice_serial_adder.sv
// Testbench for slice_serial_adder: directed corner cases on the default
// 16/4 configuration, short checks of the 8/4 and 4/4 configurations, and a
// randomized run scored against plain integer addition.
module tb_slice_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A_in;
    logic [15:0] B_in;
    logic        C_1;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        CO;

    logic        inValid8, inReady8, c8, outValid8, outReady8, co8;
    logic [7:0]  a8, b8, s8;
    logic        inValid4, inReady4, c4, outValid4, outReady4, co4;
    logic [3:0]  a4, b4, s4;

    int checks = 0;
    int errors = 0;

    // Reference model state for the randomized phase
    logic [16:0] expQ[$];
    int          inFlight = 0;
    int          age      = 0;
    int          accepted = 0;

    slice_serial_adder #(.DATA_W(16), .SLICE_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A_in(A_in), .B_in(B_in), .C_1(C_1), .out_valid(out_valid),
        .out_ready(out_ready), .S(S), .CO(CO)
    );

    slice_serial_adder #(.DATA_W(8), .SLICE_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .in_ready(inReady8),
        .A_in(a8), .B_in(b8), .C_1(c8), .out_valid(outValid8),
        .out_ready(outReady8), .S(s8), .CO(co8)
    );

    slice_serial_adder #(.DATA_W(4), .SLICE_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid4), .in_ready(inReady4),
        .A_in(a4), .B_in(b4), .C_1(c4), .out_valid(outValid4),
        .out_ready(outReady4), .S(s4), .CO(co4)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Single directed add on the 16-bit instance with constant expectations
    task automatic directedAdd(input string tag, input logic [15:0] a,
                               input logic [15:0] b, input logic c,
                               input logic [31:0] expS, input logic [31:0] expCo);
        int lat;
        @(negedge clk);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        A_in = a; B_in = b; C_1 = c; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        A_in = 16'($urandom); B_in = 16'($urandom); C_1 = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
        checkOutput({tag, "_S"}, 32'(S), expS);
        checkOutput({tag, "_CO"}, 32'(CO), expCo);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    // One random cycle: drive inputs, compare handshake and result to the model
    task automatic applyStimulus(input bit allowNew);
        logic        expReady;
        logic        expValid;
        logic [16:0] exp;
        in_valid  = allowNew && ($urandom_range(0, 9) < 7);
        A_in      = 16'($urandom);
        B_in      = 16'($urandom);
        C_1       = 1'($urandom);
        out_ready = ($urandom_range(0, 9) < 6);
        expReady  = (inFlight == 0);
        expValid  = (inFlight != 0) && (age >= 4);
        checkOutput("rnd_in_ready", 32'(in_ready), 32'(expReady));
        checkOutput("rnd_out_valid", 32'(out_valid), 32'(expValid));
        if (expValid && out_ready) begin
            exp = expQ.pop_front();
            checkOutput("rnd_S", 32'(S), 32'(exp[15:0]));
            checkOutput("rnd_CO", 32'(CO), 32'(exp[16]));
            inFlight = 0;
        end else if (inFlight != 0) begin
            age++;
        end
        if (expReady && in_valid) begin
            expQ.push_back(17'(A_in) + 17'(B_in) + 17'(C_1));
            inFlight = 1;
            age = 0;
            accepted++;
        end
        @(negedge clk);
    endtask

    // Main sequence
    initial begin
        int lat;
        int cyc;
        rst_n = 1'b0;
        in_valid = 1'b0; A_in = '0; B_in = '0; C_1 = 1'b0; out_ready = 1'b0;
        inValid8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; outReady8 = 1'b1;
        inValid4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0; outReady4 = 1'b1;

        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_S", 32'(S), 32'd0);
        checkOutput("rst_CO", 32'(CO), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        directedAdd("basic", 16'h1234, 16'h4321, 1'b1, 32'h5556, 32'd0);
        directedAdd("ripple1", 16'hFFFF, 16'h0001, 1'b0, 32'h0000, 32'd1);
        directedAdd("ripple2", 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFF, 32'd1);

        // Backpressure: result held, in_valid pulses ignored while DONE
        @(negedge clk);
        A_in = 16'h1111; B_in = 16'h2222; C_1 = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            A_in = 16'($urandom); B_in = 16'($urandom); C_1 = 1'($urandom);
            @(negedge clk);
            checkOutput("bp_S_hold", 32'(S), 32'h3333);
            checkOutput("bp_CO_hold", 32'(CO), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        end

        // Output handshake with in_valid already high: accepted one edge later
        A_in = 16'h8000; B_in = 16'h8000; C_1 = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("ovl_out_valid", 32'(out_valid), 32'd0);
        checkOutput("ovl_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("ovl_accepted", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("ovl_latency", 32'(lat), 32'd4);
        checkOutput("ovl_S", 32'(S), 32'h0001);
        checkOutput("ovl_CO", 32'(CO), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset after two slices of an in-flight add
        A_in = 16'hABCD; B_in = 16'h1357; C_1 = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_S", 32'(S), 32'd0);
        checkOutput("arst_CO", 32'(CO), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        directedAdd("post_rst", 16'h00FF, 16'h0001, 1'b0, 32'h0100, 32'd0);

        // Two-slice configuration
        @(negedge clk);
        checkOutput("v8_in_ready", 32'(inReady8), 32'd1);
        a8 = 8'hF0; b8 = 8'h0F; c8 = 1'b1; inValid8 = 1'b1;
        @(negedge clk);
        inValid8 = 1'b0;
        lat = 0;
        while (!outValid8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("v8_latency", 32'(lat), 32'd2);
        checkOutput("v8_S", 32'(s8), 32'h00);
        checkOutput("v8_CO", 32'(co8), 32'd1);

        // Single-slice configuration
        @(negedge clk);
        checkOutput("v4_in_ready", 32'(inReady4), 32'd1);
        a4 = 4'h9; b4 = 4'h8; c4 = 1'b0; inValid4 = 1'b1;
        @(negedge clk);
        inValid4 = 1'b0;
        lat = 0;
        while (!outValid4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("v4_latency", 32'(lat), 32'd1);
        checkOutput("v4_S", 32'(s4), 32'h1);
        checkOutput("v4_CO", 32'(co4), 32'd1);

        // Randomized traffic, starting from IDLE at a falling edge
        @(negedge clk);
        cyc = 0;
        while ((accepted < 1000 || inFlight != 0) && cyc < 40000) begin
            applyStimulus(accepted < 1000);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("rnd_accepted", 32'(accepted), 32'd1000);
        checkOutput("rnd_drained", 32'(inFlight), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
